// File: rtl/regfile_mp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_mp_if                                                                |
// | Write, read-port and clear bundle for the multi-port register file.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface regfile_mp_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int NRD    = 2
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [DATA_W/8-1:0]     wr_be;
  logic [NRD-1:0]          rd_en;
  logic [NRD*ADDR_W-1:0]   rd_addr;
  logic [NRD*DATA_W-1:0]   rd_data;
  logic [NRD-1:0]          rd_valid;
  logic                    clr;
  logic                    busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr,
    output rd_data, rd_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_mp                                                                   |
// | Byte-masked register file with NRD registered read ports and clear sweep.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module regfile_mp #(
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int NRD            = 2,
  parameter int RD_MODE        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_mp_if.slave   bus
);

  localparam int NBYTES = DATA_W / 8;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  localparam state_t     c_RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
  localparam logic [7:0] c_LAST      = 8'(DEPTH - 1);

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_clr_cnt, w_clr_cnt_nxt;
  logic                  w_busy;
  logic [DATA_W-1:0]     r_mem [DEPTH];
  logic                  w_wr_in_range;
  logic [DATA_W-1:0]     w_wr_old, w_wr_merged;
  logic [ADDR_W-1:0]     w_rd_addr [NRD];
  logic [NRD*DATA_W-1:0] r_rd_data, w_rd_data_nxt;
  logic [NRD-1:0]        r_rd_valid, w_rd_valid_nxt;

  assign w_busy       = (r_state == S_CLEAR);
  assign bus.busy     = w_busy;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;

  generate
    for (genvar p = 0; p < NRD; p++) begin : g_rd_addr
      assign w_rd_addr[p] = bus.rd_addr[p*ADDR_W +: ADDR_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_RST_STATE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.clr) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        if (r_clr_cnt == c_LAST) begin
          w_state_nxt   = S_IDLE;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Merged word serves both the array update and the write-first bypass.
  always_comb begin
    w_wr_in_range = (32'(bus.wr_addr) < 32'(DEPTH));
    w_wr_old      = w_wr_in_range ? r_mem[bus.wr_addr] : '0;
    w_wr_merged   = w_wr_old;
    for (int b = 0; b < NBYTES; b++) begin
      if (bus.wr_be[b]) w_wr_merged[8*b +: 8] = bus.wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_clr_cnt[ADDR_W-1:0]] <= '0;
    end else if (bus.wr_en && w_wr_in_range) begin
      r_mem[bus.wr_addr] <= w_wr_merged;
    end
  end

  always_comb begin
    w_rd_data_nxt  = r_rd_data;
    w_rd_valid_nxt = '0;
    for (int p = 0; p < NRD; p++) begin
      if (!w_busy && bus.rd_en[p]) begin
        w_rd_valid_nxt[p] = 1'b1;
        if (32'(w_rd_addr[p]) >= 32'(DEPTH)) begin
          w_rd_data_nxt[p*DATA_W +: DATA_W] = '0;
        end else if (RD_MODE == 1 && bus.wr_en && bus.wr_addr == w_rd_addr[p]) begin
          w_rd_data_nxt[p*DATA_W +: DATA_W] = w_wr_merged;
        end else begin
          w_rd_data_nxt[p*DATA_W +: DATA_W] = r_mem[w_rd_addr[p]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else begin
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_mp                                                                |
// | Self-checking bench: read-first/write-first pair plus a DEPTH=12 instance.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_mp_if #(.DATA_W(32), .DEPTH(16), .NRD(2)) if0 ();
  regfile_mp_if #(.DATA_W(32), .DEPTH(16), .NRD(2)) if1 ();
  regfile_mp_if #(.DATA_W(8),  .DEPTH(12), .NRD(1)) if2 ();

  assign if1.wr_en   = if0.wr_en;
  assign if1.wr_addr = if0.wr_addr;
  assign if1.wr_data = if0.wr_data;
  assign if1.wr_be   = if0.wr_be;
  assign if1.rd_en   = if0.rd_en;
  assign if1.rd_addr = if0.rd_addr;
  assign if1.clr     = if0.clr;

  regfile_mp #(.DATA_W(32), .DEPTH(16), .NRD(2), .RD_MODE(0), .CLEAR_ON_RESET(1))
    u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  regfile_mp #(.DATA_W(32), .DEPTH(16), .NRD(2), .RD_MODE(1), .CLEAR_ON_RESET(1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  regfile_mp #(.DATA_W(8), .DEPTH(12), .NRD(1), .RD_MODE(0), .CLEAR_ON_RESET(0))
    u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic [1:0]  rd_en;
    logic [3:0]  a0, a1;
    logic [31:0] e0_0, e0_1;   // read-first instance, ports 0/1
    logic [31:0] e1_0, e1_1;   // write-first instance, ports 0/1
  } vec_t;

  vec_t vt[$];
  vec_t sb[$];

  function automatic vec_t mk(logic we, logic [3:0] wa, logic [31:0] wd, logic [3:0] be,
                              logic [1:0] re, logic [3:0] a0, logic [3:0] a1,
                              logic [31:0] e00, logic [31:0] e01,
                              logic [31:0] e10, logic [31:0] e11);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.wr_be = be;
    v.rd_en = re; v.a0 = a0; v.a1 = a1;
    v.e0_0 = e00; v.e0_1 = e01; v.e1_0 = e10; v.e1_1 = e11;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle0();
    if0.wr_en = 1'b0; if0.wr_addr = '0; if0.wr_data = '0; if0.wr_be = '0;
    if0.rd_en = '0;   if0.rd_addr = '0; if0.clr = 1'b0;
  endtask

  task automatic idle2();
    if2.wr_en = 1'b0; if2.wr_addr = '0; if2.wr_data = '0; if2.wr_be = '0;
    if2.rd_en = '0;   if2.rd_addr = '0; if2.clr = 1'b0;
  endtask

  // Counts negedge samples with busy high, starting at the current negedge.
  task automatic count_busy(input int which, output int n);
    logic b;
    n = 0;
    forever begin
      b = (which == 2) ? if2.busy : if0.busy;
      if (!b || n >= 64) break;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    vec_t e;

    idle0();
    idle2();
    repeat (2) @(negedge clk);
    chk("rst_busy_u0", 64'(if0.busy), 64'd1);
    chk("rst_busy_u2", 64'(if2.busy), 64'd0);
    chk("rst_valid_u0", 64'(if0.rd_valid), 64'd0);
    chk("rst_data_u0", if0.rd_data, 64'd0);

    rst_n = 1'b1;
    count_busy(0, n);
    chk("reset_sweep_len", 64'(n), 64'd16);
    chk("reset_sweep_u1_done", 64'(if1.busy), 64'd0);

    for (int i = 0; i < 8; i++)
      vt.push_back(mk(0, 0, 0, 0, 2'b11, 4'(i), 4'(i + 8), 0, 0, 0, 0));
    vt.push_back(mk(1, 3, 32'hAABBCCDD, 4'hF, 2'b00, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 3, 32'h11223344, 4'b0101, 2'b11, 3, 3,
                    32'hAABBCCDD, 32'hAABBCCDD, 32'hAA22CC44, 32'hAA22CC44));
    vt.push_back(mk(0, 0, 0, 0, 2'b11, 3, 0, 32'hAA22CC44, 0, 32'hAA22CC44, 0));
    vt.push_back(mk(1, 7, 32'h5A, 4'b0001, 2'b11, 7, 8, 0, 0, 32'h5A, 0));
    vt.push_back(mk(0, 0, 0, 0, 2'b11, 7, 7, 32'h5A, 32'h5A, 32'h5A, 32'h5A));
    vt.push_back(mk(1, 7, 32'hFFFFFFFF, 4'b0000, 2'b10, 0, 7, 0, 32'h5A, 0, 32'h5A));
    vt.push_back(mk(0, 0, 0, 0, 2'b01, 7, 0, 32'h5A, 0, 32'h5A, 0));
    vt.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 3, 32'h99999999, 4'b1000, 2'b01, 3, 0,
                    32'hAA22CC44, 0, 32'h9922CC44, 0));
    vt.push_back(mk(0, 0, 0, 0, 2'b11, 3, 3,
                    32'h9922CC44, 32'h9922CC44, 32'h9922CC44, 32'h9922CC44));

    foreach (vt[i]) begin
      if0.wr_en = vt[i].wr_en; if0.wr_addr = vt[i].wr_addr;
      if0.wr_data = vt[i].wr_data; if0.wr_be = vt[i].wr_be;
      if0.rd_en = vt[i].rd_en; if0.rd_addr = {vt[i].a1, vt[i].a0};
      sb.push_back(vt[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("v%0d_valid_u0", i), 64'(if0.rd_valid), 64'(e.rd_en));
      chk($sformatf("v%0d_valid_u1", i), 64'(if1.rd_valid), 64'(e.rd_en));
      if (e.rd_en[0]) begin
        chk($sformatf("v%0d_u0_p0", i), 64'(if0.rd_data[31:0]), 64'(e.e0_0));
        chk($sformatf("v%0d_u1_p0", i), 64'(if1.rd_data[31:0]), 64'(e.e1_0));
      end
      if (e.rd_en[1]) begin
        chk($sformatf("v%0d_u0_p1", i), 64'(if0.rd_data[63:32]), 64'(e.e0_1));
        chk($sformatf("v%0d_u1_p1", i), 64'(if1.rd_data[63:32]), 64'(e.e1_1));
      end
    end
    idle0();

    // Fill with ones, then clear while hammering every input.
    for (int a = 0; a < 16; a++) begin
      if0.wr_en = 1'b1; if0.wr_addr = 4'(a); if0.wr_data = 32'hFFFFFFFF; if0.wr_be = 4'hF;
      @(negedge clk);
    end
    idle0();
    if0.rd_en = 2'b11; if0.rd_addr = {4'd15, 4'd5};
    @(negedge clk);
    chk("fill_read_u0", if0.rd_data, {32'hFFFFFFFF, 32'hFFFFFFFF});
    idle0();
    if0.clr = 1'b1;
    @(negedge clk);
    if0.clr = 1'b0;
    n = 0;
    while (if0.busy && n < 64) begin
      chk($sformatf("sweep%0d_valid_u0", n), 64'(if0.rd_valid), 64'd0);
      chk($sformatf("sweep%0d_valid_u1", n), 64'(if1.rd_valid), 64'd0);
      if0.wr_en = 1'b1; if0.wr_addr = 4'(n); if0.wr_data = 32'h12345678; if0.wr_be = 4'hF;
      if0.rd_en = 2'b11; if0.rd_addr = {4'(n), 4'(n)};
      if0.clr = (n == 5);
      n++;
      @(negedge clk);
    end
    idle0();
    chk("sweep_len", 64'(n), 64'd16);
    chk("sweep_end_valid", 64'(if0.rd_valid), 64'd0);
    chk("sweep_hold_data", if0.rd_data, {32'hFFFFFFFF, 32'hFFFFFFFF});
    for (int i = 0; i < 8; i++) begin
      if0.rd_en = 2'b11; if0.rd_addr = {4'(i + 8), 4'(i)};
      @(negedge clk);
      chk($sformatf("post_clr%0d_u0", i), {30'd0, if0.rd_valid, if0.rd_data[63:32]} ^ 64'(if0.rd_data[31:0]),
          {30'd0, 2'b11, 32'd0});
      chk($sformatf("post_clr%0d_u1", i), if1.rd_data, 64'd0);
    end
    idle0();

    // Reset in the middle of a sweep.
    if0.wr_en = 1'b1; if0.wr_addr = 4; if0.wr_data = 32'hDEADBEEF; if0.wr_be = 4'hF;
    @(negedge clk);
    idle0();
    if0.rd_en = 2'b01; if0.rd_addr = {4'd0, 4'd4};
    @(negedge clk);
    chk("pre_rst_read", 64'(if0.rd_data[31:0]), 64'hDEADBEEF);
    idle0();
    if0.clr = 1'b1;
    @(negedge clk);
    if0.clr = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_sweep_busy", 64'(if0.busy), 64'd1);
    chk("mid_sweep_hold", 64'(if0.rd_data[31:0]), 64'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chk("rst_async_data", if0.rd_data, 64'd0);
    chk("rst_async_busy", 64'(if0.busy), 64'd1);
    chk("rst_async_u2_busy", 64'(if2.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(0, n);
    chk("restart_sweep_len", 64'(n), 64'd16);

    // DEPTH=12 instance: out-of-range write/read and its own sweep length.
    if2.wr_en = 1'b1; if2.wr_addr = 11; if2.wr_data = 8'h3C; if2.wr_be = 1'b1;
    @(negedge clk);
    if2.wr_addr = 13; if2.wr_data = 8'h77;
    @(negedge clk);
    idle2();
    if2.rd_en = 1'b1; if2.rd_addr = 13;
    @(negedge clk);
    chk("oor_read_valid", 64'(if2.rd_valid), 64'd1);
    chk("oor_read_data", 64'(if2.rd_data), 64'd0);
    if2.rd_addr = 11;
    @(negedge clk);
    chk("d12_last_entry", 64'(if2.rd_data), 64'h3C);
    idle2();
    if2.clr = 1'b1;
    @(negedge clk);
    if2.clr = 1'b0;
    count_busy(2, n);
    chk("d12_sweep_len", 64'(n), 64'd12);
    if2.rd_en = 1'b1; if2.rd_addr = 11;
    @(negedge clk);
    chk("d12_post_clr", {63'd0, if2.rd_valid} << 8 | 64'(if2.rd_data), 64'h100);
    idle2();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
